ov7670_reg_cfg: RTL and testbench

Register-initialisation sequencer for the OV7670 camera. After the SCCB writer reports it is ready (init_en), this block walks an external register look-up table of {addr, data} pairs. It issues one SCCB write per entry over a request/done handshake, and inserts the settling delay that a soft reset (COM7 bit7) requires. It sits between the board-level ROM and the SCCB write engine, and reports completion or failure to the capture pipeline.

---
 rtl/ov7670_reg_cfg.sv | 131 +++++++++++++
 tb/tb_ov7670_reg_cfg.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_reg_cfg.sv
// OV7670 register-initialisation sequencer: walks an {addr,data} LUT and issues
// one SCCB write per entry, with timeout/retry and a settling delay after COM7 soft reset.
module ov7670_reg_cfg #(
  parameter logic [7:0]  REG_NUM      = 8'd165,
  parameter logic [15:0] GAP_CYC      = 16'd200,
  parameter logic [19:0] TIMEOUT_CYC  = 20'd50_000,
  parameter logic [1:0]  MAX_RETRY    = 2'd3,
  parameter logic [19:0] RST_WAIT_CYC = 20'd500_000
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        init_en,
  input  logic        cfg_restart,
  output logic [7:0]  lut_index,
  input  logic [15:0] lut_data,
  output logic        sccb_req,
  output logic [7:0]  sccb_addr,
  output logic [7:0]  sccb_data,
  input  logic        sccb_done,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [7:0]  err_index
);

  typedef enum logic [2:0] {
    WAIT_INIT, FETCH, REQ, BUSY, GAP, RST_WAIT, DONE, ERROR
  } state_t;

  state_t      state, state_nxt;
  logic [19:0] cnt;
  logic [1:0]  retry_cnt;
  logic [20:0] cnt_inc;
  logic        gap_end, rst_end, tmo_hit, fetch_end, last_idx, com7_rst;
  logic        idx_adv, retry_inc, retry_clr, restart_clr;

  // Thresholds compare against cnt+1 so a zero-length parameter still exits after one cycle.
  always_comb begin
    cnt_inc   = {1'b0, cnt} + 21'd1;
    gap_end   = cnt_inc >= {5'd0, GAP_CYC};
    rst_end   = cnt_inc >= {1'b0, RST_WAIT_CYC};
    tmo_hit   = cnt_inc >= {1'b0, TIMEOUT_CYC};
    fetch_end = (cnt != '0);
    last_idx  = (lut_index == REG_NUM - 8'd1);
    com7_rst  = (sccb_addr == 8'h12) && sccb_data[7];
  end

  always_comb begin
    state_nxt   = state;
    idx_adv     = 1'b0;
    retry_inc   = 1'b0;
    retry_clr   = 1'b0;
    restart_clr = 1'b0;
    case (state)
      WAIT_INIT: begin
        if (init_en) state_nxt = (REG_NUM == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (fetch_end) state_nxt = REQ;
      end
      REQ: state_nxt = BUSY;
      BUSY: begin
        if (sccb_done) begin
          retry_clr = 1'b1;
          state_nxt = com7_rst ? RST_WAIT : GAP;
        end else if (tmo_hit) begin
          if (retry_cnt == MAX_RETRY) begin
            state_nxt = ERROR;
          end else begin
            retry_inc = 1'b1;
            state_nxt = GAP;
          end
        end
      end
      GAP, RST_WAIT: begin
        // A nonzero retry count here means the last attempt timed out: re-issue the same entry.
        if ((state == GAP) ? gap_end : rst_end) begin
          if (retry_cnt != '0) begin
            state_nxt = FETCH;
          end else if (last_idx) begin
            state_nxt = DONE;
          end else begin
            idx_adv   = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      DONE, ERROR: begin
        if (cfg_restart) begin
          restart_clr = 1'b1;
          state_nxt   = WAIT_INIT;
        end
      end
      default: state_nxt = WAIT_INIT;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_INIT;
      cnt       <= '0;
      retry_cnt <= '0;
      lut_index <= '0;
      sccb_req  <= 1'b0;
      sccb_addr <= '0;
      sccb_data <= '0;
      err_index <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + 20'd1;
      sccb_req <= (state_nxt == BUSY);
      if (state == FETCH && fetch_end) begin
        sccb_addr <= lut_data[15:8];
        sccb_data <= lut_data[7:0];
      end
      if (restart_clr || retry_clr) retry_cnt <= '0;
      else if (retry_inc)           retry_cnt <= retry_cnt + 2'd1;
      if (restart_clr)  lut_index <= '0;
      else if (idx_adv) lut_index <= lut_index + 8'd1;
      if (state_nxt == ERROR && state != ERROR) err_index <= lut_index;
    end
  end

  always_comb begin
    cfg_busy = state inside {FETCH, REQ, BUSY, GAP, RST_WAIT};
    cfg_done = (state == DONE);
    cfg_err  = (state == ERROR);
  end

endmodule

// File: tb/tb_ov7670_reg_cfg.sv
// Bench for ov7670_reg_cfg: a schedule model predicts every write window and flag
// edge from the LUT contents and the per-attempt response plan.
module tb_ov7670_reg_cfg;
  localparam int NREG = 4;
  localparam int GAPC = 6;
  localparam int TMO  = 150;
  localparam int MAXR = 3;
  localparam int RSTW = 300;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_en = 1'b0;
  logic        restart_a = 1'b0;
  logic        restart_b = 1'b0;
  logic        cfg_restart;
  logic        sccb_done = 1'b0;
  logic [7:0]  lut_index;
  logic [15:0] lut_data = '0;
  logic        sccb_req;
  logic [7:0]  sccb_addr, sccb_data, err_index;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [7:0]  z_index, z_addr, z_data, z_err_index;
  logic        z_req, z_busy, z_done, z_err;

  logic [15:0] lut [NREG];
  int cyc = 0;
  int checks = 0, errors = 0;

  int plan[$], resp_q[$], a_rise[$], a_fall[$], a_idx[$];
  int s0 = 0, end_edge = 0, outcome = 0, m_err_idx = 0;
  int first_rise = -1, rise_cnt = 0;
  bit mon_en = 0, mon_prev = 0, busy_rst_en = 0, spur_en = 0;

  assign cfg_restart = restart_a | restart_b;

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;
  always @(posedge sclk) lut_data <= lut[lut_index[1:0]];

  ov7670_reg_cfg #(
    .REG_NUM(8'(NREG)), .GAP_CYC(16'(GAPC)), .TIMEOUT_CYC(20'(TMO)),
    .MAX_RETRY(2'(MAXR)), .RST_WAIT_CYC(20'(RSTW))
  ) dut (
    .sclk(sclk), .rst_n(rst_n), .init_en(init_en), .cfg_restart(cfg_restart),
    .lut_index(lut_index), .lut_data(lut_data), .sccb_req(sccb_req),
    .sccb_addr(sccb_addr), .sccb_data(sccb_data), .sccb_done(sccb_done),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_index(err_index)
  );

  ov7670_reg_cfg #(
    .REG_NUM(8'd0), .GAP_CYC(16'(GAPC)), .TIMEOUT_CYC(20'(TMO)),
    .MAX_RETRY(2'(MAXR)), .RST_WAIT_CYC(20'(RSTW))
  ) dut_empty (
    .sclk(sclk), .rst_n(rst_n), .init_en(init_en), .cfg_restart(1'b0),
    .lut_index(z_index), .lut_data(16'h0000), .sccb_req(z_req),
    .sccb_addr(z_addr), .sccb_data(z_data), .sccb_done(1'b0),
    .cfg_busy(z_busy), .cfg_done(z_done), .cfg_err(z_err), .err_index(z_err_index)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Schedule model: sample n (after posedge n) sees req high for rise <= n < fall.
  task automatic build(input int s);
    int pos, idx, k, retries, d, rise, fall, w;
    a_rise.delete(); a_fall.delete(); a_idx.delete();
    pos = s; idx = 0; k = 0; retries = 0;
    forever begin
      rise = pos + 3;
      d = (k < plan.size()) ? plan[k] : 1;
      k++;
      fall = (d > 0) ? rise + d : rise + TMO;
      a_rise.push_back(rise); a_fall.push_back(fall); a_idx.push_back(idx);
      if (d == 0) begin
        if (retries == MAXR) begin
          end_edge = fall; outcome = 2; m_err_idx = idx;
          break;
        end
        retries++;
        pos = fall + GAPC;
      end else begin
        retries = 0;
        w = (lut[idx][15:8] == 8'h12 && lut[idx][7]) ? RSTW : GAPC;
        if (idx == NREG - 1) begin
          end_edge = fall + w; outcome = 1;
          break;
        end
        pos = fall + w;
        idx++;
      end
    end
  endtask

  // SCCB responder: answers each request after its planned delay (0 = never).
  always @(negedge sclk) begin : resp
    int d, fire;
    bit prev;
    if (!rst_n) begin
      sccb_done = 1'b0; restart_b = 1'b0; prev = 0; fire = -1;
    end else begin
      restart_b = 1'b0;
      if (sccb_req && !prev) begin
        d = (resp_q.size() > 0) ? resp_q.pop_front() : 1;
        fire = (d > 0) ? cyc + d - 1 : -1;
        if (busy_rst_en && $urandom_range(0, 2) == 0) restart_b = 1'b1;
      end
      sccb_done = (cyc == fire) || (spur_en && !sccb_req && $urandom_range(0, 9) == 0);
      prev = sccb_req;
    end
  end

  always @(negedge sclk) begin : cmp
    int n, ai;
    logic [15:0] w;
    if (mon_en) begin
      n = cyc; ai = -1;
      for (int i = 0; i < a_rise.size(); i++)
        if (n >= a_rise[i] && n < a_fall[i]) ai = i;
      chk("sccb_req", sccb_req, ai >= 0);
      if (ai >= 0) begin
        w = lut[a_idx[ai]];
        chk("sccb_addr", sccb_addr, w[15:8]);
        chk("sccb_data", sccb_data, w[7:0]);
        chk("lut_index", lut_index, a_idx[ai]);
      end
      chk("cfg_busy", cfg_busy, n >= s0 && n < end_edge);
      chk("cfg_done", cfg_done, n >= end_edge && outcome == 1);
      chk("cfg_err", cfg_err, n >= end_edge && outcome == 2);
      if (n >= end_edge && outcome == 2) chk("err_index", err_index, m_err_idx);
      if (sccb_req && !mon_prev) begin
        rise_cnt++;
        if (first_rise < 0) first_rise = n;
      end
    end
    mon_prev = sccb_req;
  end

  function automatic int rand_d();
    int r;
    r = $urandom_range(0, 3);
    return (r == 0) ? 1 : (r == 1) ? TMO : $urandom_range(1, TMO);
  endfunction

  task automatic gen_lut(input bit allow_com7);
    int k;
    for (int i = 0; i < NREG; i++) begin
      lut[i] = 16'($urandom);
      if (lut[i][15:8] == 8'h12) lut[i][15:8] = 8'h13;
    end
    if (allow_com7) begin
      k = $urandom_range(0, NREG - 1);
      lut[k] = {8'h12, 1'($urandom_range(0, 1)), 7'($urandom)};
    end
  endtask

  task automatic gen_plan(input bit allow_to);
    plan.delete();
    for (int i = 0; i < 24; i++)
      plan.push_back((allow_to && $urandom_range(0, 4) == 0) ? 0 : rand_d());
  endtask

  task automatic start_scn();
    resp_q = plan;
    s0 = cyc + 1;
    build(s0);
    first_rise = -1; rise_cnt = 0;
    init_en = 1'b1;
    mon_en = 1;
  endtask

  task automatic run_scn(input int drop_at);
    @(negedge sclk);
    start_scn();
    while (cyc < end_edge + 5) begin
      @(negedge sclk);
      if (drop_at > 0 && cyc == s0 + drop_at) init_en = 1'b0;
    end
    mon_en = 0;
  endtask

  task automatic restart_seq(input string tag);
    @(negedge sclk);
    init_en = 1'b0; restart_a = 1'b1;
    @(negedge sclk);
    restart_a = 1'b0;
    chk({tag, "_done_clr"}, cfg_done, 0);
    chk({tag, "_err_clr"}, cfg_err, 0);
    chk({tag, "_idx_clr"}, lut_index, 0);
    repeat (5) @(negedge sclk);
    chk({tag, "_idle_busy"}, cfg_busy, 0);
    chk({tag, "_idle_req"}, sccb_req, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, sccb_req, 0);
    chk({tag, "_addr"}, sccb_addr, 0);
    chk({tag, "_data"}, sccb_data, 0);
    chk({tag, "_index"}, lut_index, 0);
    chk({tag, "_busy"}, cfg_busy, 0);
    chk({tag, "_done"}, cfg_done, 0);
    chk({tag, "_err"}, cfg_err, 0);
    chk({tag, "_err_index"}, err_index, 0);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) lut[i] = '0;
    repeat (3) @(negedge sclk);
    chk_reset_outputs("reset");
    chk("empty_done_reset", z_done, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge sclk);
    chk("idle_busy", cfg_busy, 0);
    chk("idle_req", sccb_req, 0);

    // Basic sequence with a COM7 soft reset first
    lut[0] = 16'h1280; lut[1] = 16'h1101; lut[2] = 16'h3A04; lut[3] = 16'h4B1E;
    plan = '{100, 100, 100, 100};
    run_scn(0);
    chk("basic_end_offset", end_edge - s0, 730);
    chk("basic_req_latency", first_rise - s0, 3);
    chk("basic_rises", rise_cnt, 4);
    chk("basic_done", cfg_done, 1);
    chk("basic_busy", cfg_busy, 0);
    chk("empty_table_done", z_done, 1);
    chk("empty_table_busy", z_busy, 0);
    restart_seq("basic_restart");

    // Entry 1 times out twice, then succeeds
    gen_lut(0);
    plan = '{rand_d(), 0, 0, rand_d(), rand_d(), rand_d()};
    run_scn(0);
    chk("retry_rises", rise_cnt, 6);
    chk("retry_done", cfg_done, 1);
    chk("retry_err", cfg_err, 0);
    restart_seq("retry_restart");

    // Entry 2 never answered: four attempts then error
    gen_lut(0);
    plan = '{rand_d(), rand_d(), 0, 0, 0, 0};
    run_scn(0);
    chk("err_rises", rise_cnt, 6);
    chk("err_flag", cfg_err, 1);
    chk("err_index_val", err_index, 2);
    chk("err_done", cfg_done, 0);
    chk("err_req", sccb_req, 0);
    restart_seq("err_restart");

    gen_lut(1); gen_plan(0); busy_rst_en = 1;
    run_scn(0);
    restart_seq("rerun_restart");

    // Reset asserted while the second write is in flight
    gen_lut(0); gen_plan(0); busy_rst_en = 0;
    @(negedge sclk);
    start_scn();
    for (int k = 0; k < 3000 && !(sccb_req && lut_index == 8'd1); k++) @(negedge sclk);
    mon_en = 0;
    chk("midrst_req_seen", sccb_req, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    init_en = 1'b0;
    @(negedge sclk);
    rst_n = 1'b1;
    repeat (8) @(negedge sclk);
    chk("midrst_wait_busy", cfg_busy, 0);
    chk("midrst_wait_req", sccb_req, 0);
    chk("midrst_wait_index", lut_index, 0);

    busy_rst_en = 1; spur_en = 1;
    for (int r = 0; r < 4; r++) begin
      gen_lut($urandom_range(0, 1) == 1);
      gen_plan(1);
      run_scn($urandom_range(1, 50));
      restart_seq("rand_restart");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
